link_master: RTL and testbench

LINK_MASTER -- requirements
Module: link_master

---
 rtl/link_pkg.sv | 14 +
 rtl/link_master.sv | 81 ++++++++
 tb/tb_link_master.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared link protocol constants, FSM encoding and byte helper
package link_pkg;
  typedef logic [1:0] state_t;
  localparam int NUM_BYTES = 4;
  localparam logic [3:0] WDOG_LIMIT = 4'd15;
  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ASSERT_REQ = 2'd1;
  localparam state_t S_WAIT_ACK_LOW = 2'd2;
  localparam state_t S_DONE = 2'd3;
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction
endpackage

// File: rtl/link_master.sv
// link_master: 4-phase handshake master sending one 4-byte burst per start, with watchdog
module link_master
  import link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] tx_data,
  input  logic        ack,
  output logic        req,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);
  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_buf;
  logic [3:0]  r_wdog;
  logic        r_req;
  logic [7:0]  r_data;
  logic        r_to;
  logic        w_wdog_exp;
  logic [1:0]  w_next_idx;
  assign w_wdog_exp = r_wdog == WDOG_LIMIT - 4'd1;
  assign w_next_idx = r_idx + 2'd1;
  assign req = r_req;
  assign data_out = r_data;
  assign timeout_err = r_to;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  // handshake sequencing; watchdog clears on every state entry, the last count before 15 aborts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_idx <= 2'd0;
      r_buf <= 32'd0;
      r_wdog <= 4'd0;
      r_req <= 1'b0;
      r_data <= 8'd0;
      r_to <= 1'b0;
    end else case (r_state)
      S_IDLE: if (start) begin
        r_buf <= tx_data;
        r_idx <= 2'd0;
        r_to <= 1'b0;
        r_req <= 1'b1;
        r_data <= tx_data[7:0];
        r_wdog <= 4'd0;
        r_state <= S_ASSERT_REQ;
      end
      S_ASSERT_REQ: if (ack) begin
        r_req <= 1'b0;
        r_wdog <= 4'd0;
        r_state <= S_WAIT_ACK_LOW;
      end else if (w_wdog_exp) begin
        r_to <= 1'b1;
        r_req <= 1'b0;
        r_wdog <= 4'd0;
        r_state <= S_IDLE;
      end else r_wdog <= r_wdog + 4'd1;
      S_WAIT_ACK_LOW: if (!ack) begin
        r_wdog <= 4'd0;
        if (r_idx == LAST_IDX) r_state <= S_DONE;
        else begin
          r_idx <= w_next_idx;
          r_req <= 1'b1;
          r_data <= byte_sel(r_buf, w_next_idx);
          r_state <= S_ASSERT_REQ;
        end
      end else if (w_wdog_exp) begin
        r_to <= 1'b1;
        r_wdog <= 4'd0;
        r_state <= S_IDLE;
      end else r_wdog <= r_wdog + 4'd1;
      default: begin
        r_wdog <= 4'd0;
        r_state <= S_IDLE;
      end
    endcase
endmodule

// File: tb/tb_link_master.sv
// tb_link_master: randomized scoreboard bench with a behavioural link slave
module tb_link_master;
  logic clk = 1'b0;
  logic rst, start, ack;
  logic [31:0] tx_data;
  logic req, busy, done, timeout_err;
  logic [7:0] data_out;
  int checks = 0, failures = 0, mode = 0, req_rises = 0;
  logic [7:0] exp_b[$];
  bit exp_o[$];
  link_master dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .ack(ack),
    .req(req), .data_out(data_out), .busy(busy), .done(done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask
  task automatic push_burst(input logic [31:0] d, input bit tmo_first);
    if (tmo_first) begin
      exp_b.push_back(d[7:0]);
      exp_o.push_back(1'b1);
    end else begin
      for (int i = 0; i < 4; i++) exp_b.push_back(8'((d >> (8 * i)) & 32'hff));
      exp_o.push_back(1'b0);
    end
  endtask
  task automatic pulse_start(input logic [31:0] d);
    @(negedge clk);
    tx_data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 0);
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done, 1);
  endtask
  task automatic wait_rises(input int target, input string nm);
    int n = 0;
    while (req_rises < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, req_rises >= target, 1);
  endtask
  initial begin
    int lat, hold;
    ack = 1'b0;
    lat = $urandom_range(0, 3);
    hold = 0;
    forever begin
      @(negedge clk);
      if (rst || mode == 1) begin
        ack = 1'b0;
        lat = $urandom_range(0, 3);
      end else if (mode == 2) begin
        if (req) ack = 1'b1;
      end else if (!ack && req) begin
        if (lat == 0) begin
          ack = 1'b1;
          hold = $urandom_range(0, 2);
        end else lat--;
      end else if (ack && !req) begin
        if (hold == 0) begin
          ack = 1'b0;
          lat = $urandom_range(0, 3);
        end else hold--;
      end
    end
  end
  initial begin
    logic p_req = 1'b0, p_done = 1'b0, p_to = 1'b0;
    logic [7:0] held = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (req && !p_req) begin
          req_rises++;
          chk("req_while_ack", ack, 0);
          chk("byte_expected", exp_b.size() != 0, 1);
          if (exp_b.size() != 0) chk("byte_value", data_out, exp_b.pop_front());
          held = data_out;
        end else if (req && p_req) chk("data_stable", data_out, held);
        if (done) begin
          chk("done_single_cycle", p_done, 0);
          chk("done_expected", exp_o.size() != 0, 1);
          if (exp_o.size() != 0) chk("outcome_done", exp_o.pop_front(), 0);
        end
        if (timeout_err && !p_to) begin
          chk("timeout_expected", exp_o.size() != 0, 1);
          if (exp_o.size() != 0) chk("outcome_timeout", exp_o.pop_front(), 1);
        end
      end
      p_req = req;
      p_done = done;
      p_to = timeout_err;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit expired");
  end
  initial begin
    logic [31:0] d;
    int n, base;
    rst = 1'b1;
    start = 1'b0;
    tx_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_burst(32'hDEADBEEF, 0);
    pulse_start(32'hDEADBEEF);
    wait_idle("deadbeef_idle");
    chk("deadbeef_tmo", timeout_err, 0);
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      push_burst(d, 0);
      pulse_start(d);
      wait_idle("rand_idle");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    mode = 1;
    d = $urandom;
    push_burst(d, 1);
    pulse_start(d);
    n = 0;
    while (req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", n, 15);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    mode = 0;
    repeat (3) @(negedge clk);
    mode = 2;
    d = $urandom;
    push_burst(d, 1);
    pulse_start(d);
    n = 0;
    while (req && n < 40) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (busy && n < 40) begin
      chk("stuck_req_low", req, 0);
      n++;
      @(negedge clk);
    end
    chk("stuck_wait_cycles", n, 15);
    chk("stuck_flag", timeout_err, 1);
    mode = 0;
    repeat (6) @(negedge clk);
    d = $urandom;
    push_burst(d, 0);
    base = req_rises;
    pulse_start(d);
    wait_rises(base + 2, "second_start_wait");
    tx_data = ~d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("second_start_idle");
    chk("second_start_tmo", timeout_err, 0);
    repeat (2) @(negedge clk);
    d = $urandom;
    push_burst(d, 0);
    base = req_rises;
    pulse_start(d);
    wait_rises(base + 3, "rst_mid_wait");
    chk("rst_mid_req_before", req, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_req", req, 0);
    chk("rst_mid_data", data_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_tmo", timeout_err, 0);
    exp_b.delete();
    exp_o.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_burst(32'h01020304, 0);
    pulse_start(32'h01020304);
    wait_idle("post_rst_idle");
    chk("post_rst_tmo", timeout_err, 0);
    repeat (2) @(negedge clk);
    push_burst(32'h11223344, 0);
    push_burst(32'h11223344, 0);
    tx_data = 32'h11223344;
    start = 1'b1;
    wait_done("held_done1");
    @(negedge clk);
    chk("held_gap_idle", busy, 0);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_req", req, 1);
    @(negedge clk);
    wait_done("held_done2");
    start = 1'b0;
    wait_idle("held_idle");
    repeat (3) @(negedge clk);
    chk("held_no_third", busy, 0);
    repeat (3) @(negedge clk);
    chk("bytes_left", exp_b.size(), 0);
    chk("outcomes_left", exp_o.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
